// File: rtl/alp_dq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alp_dq_pkg
// Description : Shared types and constants for the ALP Q/D shifter datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package alp_dq_pkg;

    localparam int Q_OP_W    = 3;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 6;

    typedef enum logic [Q_OP_W-1:0] {
        Q_HOLD   = 3'b000,
        Q_LOAD_A = 3'b001,
        Q_LOAD_W = 3'b010,
        Q_SHL1   = 3'b011,
        Q_SHR1   = 3'b100,
        Q_SHL_N  = 3'b101,
        Q_SHR_N  = 3'b110,
        Q_RSVD   = 3'b111
    } q_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } dq_state_t;

endpackage
`default_nettype wire

// File: rtl/alp_dq_shifter_if.sv
`default_nettype none
// ============================================================================
// Module      : alp_dq_shifter_if
// Description : Operation/data bus between the microsequencer and the shifter.
// Revision    : 1.0 - initial release
// ============================================================================
interface alp_dq_shifter_if
    import alp_dq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
);

    logic [Q_OP_W-1:0] q_op_h;
    logic [WIDTH-1:0]  a_h;
    logic [WIDTH-1:0]  w_h;
    logic              d_we_h;
    logic              dreg_inh_l;
    logic [CNT_W-1:0]  shift_cnt_h;
    logic              q_sin_h;
    logic [WIDTH-1:0]  q_h;
    logic [WIDTH-1:0]  d_h;
    logic              q_sout_h;
    logic              busy_h;
    logic              done_h;

    modport master (
        output q_op_h, a_h, w_h, d_we_h, dreg_inh_l, shift_cnt_h, q_sin_h,
        input  q_h, d_h, q_sout_h, busy_h, done_h
    );

    modport slave (
        input  q_op_h, a_h, w_h, d_we_h, dreg_inh_l, shift_cnt_h, q_sin_h,
        output q_h, d_h, q_sout_h, busy_h, done_h
    );

endinterface
`default_nettype wire

// File: rtl/alp_dq_shift_unit.sv
`default_nettype none
// ============================================================================
// Module      : alp_dq_shift_unit
// Description : Combinational one-step shifter with serial in/out (dir 1 = right).
// Revision    : 1.0 - initial release
// ============================================================================
module alp_dq_shift_unit #(
    parameter int WIDTH = 32
) (
    input  wire logic [WIDTH-1:0] i_operand,
    input  wire logic             i_dir,
    input  wire logic             i_sin,
    output logic      [WIDTH-1:0] o_result,
    output logic                  o_sout
);

    always_comb begin
        if (i_dir) begin
            o_result = {i_sin, i_operand[WIDTH-1:1]};
            o_sout   = i_operand[0];
        end else begin
            o_result = {i_operand[WIDTH-2:0], i_sin};
            o_sout   = i_operand[WIDTH-1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/alp_dq_shifter.sv
`default_nettype none
// ============================================================================
// Module      : alp_dq_shifter
// Description : Q/D register pair with single-step ops and an N-step shift
//               sequencer. Define ALP_DQ_DSHIFT_EN to make N-step ops shift
//               the double-width {D,Q} pair.
// Revision    : 1.0 - initial release
// ============================================================================
module alp_dq_shifter
    import alp_dq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  wire logic         clk,
    input  wire logic         reset_l,
    alp_dq_shifter_if.slave   bus
);

`ifdef ALP_DQ_DSHIFT_EN
    localparam int c_SU_W = 2 * WIDTH;
`else
    localparam int c_SU_W = WIDTH;
`endif

    q_op_t            w_op;
    dq_state_t        r_state;
    dq_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_dir;
    logic             w_dir_nxt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_nxt;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] w_d_nxt;
    logic             r_sout;
    logic             w_sout_nxt;
    logic             r_busy;
    logic             r_done;
    logic             w_seq;
    logic             w_nop;

    logic [c_SU_W-1:0] w_su_op;
    logic [c_SU_W-1:0] w_su_res;
    logic              w_su_dir;
    logic              w_su_sout;

    assign w_op  = q_op_t'(bus.q_op_h);
    assign w_seq = (r_state == ST_SHIFT);
    assign w_nop = !r_busy && ((w_op == Q_SHL_N) || (w_op == Q_SHR_N));

    // ------------------------------------------------------------------------
    // Sequencer next-state
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dir_nxt   = r_dir;
        case (r_state)
            ST_SHIFT: begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                if (w_nop) begin
                    w_dir_nxt = (w_op == Q_SHR_N);
                    if (bus.shift_cnt_h == '0) begin
                        w_state_nxt = ST_DONE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = ST_SHIFT;
                        w_cnt_nxt   = bus.shift_cnt_h;
                    end
                end
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Shifter operand selection
    // ------------------------------------------------------------------------
    always_comb begin
        w_su_dir = w_seq ? r_dir : (w_op == Q_SHR1);
`ifdef ALP_DQ_DSHIFT_EN
        // Single-step ops stay Q-only: the upper half is padded so the wide
        // unit yields exactly the Q-only result and shifted-out bit.
        if (w_seq) begin
            w_su_op = {r_d, r_q};
        end else if (w_su_dir) begin
            w_su_op = {{(WIDTH-1){1'b0}}, bus.q_sin_h, r_q};
        end else begin
            w_su_op = {r_q[WIDTH-1], {(WIDTH-1){1'b0}}, r_q};
        end
`else
        w_su_op = r_q;
`endif
    end

    alp_dq_shift_unit #(
        .WIDTH     (c_SU_W)
    ) u_shift_unit (
        .i_operand (w_su_op),
        .i_dir     (w_su_dir),
        .i_sin     (bus.q_sin_h),
        .o_result  (w_su_res),
        .o_sout    (w_su_sout)
    );

    // ------------------------------------------------------------------------
    // Q/D datapath next values
    // ------------------------------------------------------------------------
    always_comb begin
        w_q_nxt    = r_q;
        w_d_nxt    = r_d;
        w_sout_nxt = r_sout;
        if (w_seq) begin
            w_q_nxt    = w_su_res[WIDTH-1:0];
            w_sout_nxt = w_su_sout;
`ifdef ALP_DQ_DSHIFT_EN
            w_d_nxt    = w_su_res[c_SU_W-1:WIDTH];
`endif
        end else begin
            case (w_op)
                Q_LOAD_A: w_q_nxt = bus.a_h;
                Q_LOAD_W: w_q_nxt = bus.w_h;
                Q_SHL1, Q_SHR1: begin
                    w_q_nxt    = w_su_res[WIDTH-1:0];
                    w_sout_nxt = w_su_sout;
                end
                default: ;
            endcase
            if (bus.d_we_h && bus.dreg_inh_l) begin
                w_d_nxt = bus.w_h;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
            r_q     <= '0;
            r_d     <= '0;
            r_sout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dir   <= w_dir_nxt;
            r_q     <= w_q_nxt;
            r_d     <= w_d_nxt;
            r_sout  <= w_sout_nxt;
            r_busy  <= (w_state_nxt == ST_SHIFT);
            r_done  <= (w_state_nxt == ST_DONE);
        end
    end

    assign bus.q_h      = r_q;
    assign bus.d_h      = r_d;
    assign bus.q_sout_h = r_sout;
    assign bus.busy_h   = r_busy;
    assign bus.done_h   = r_done;

endmodule
`default_nettype wire
